uart_xcvr_param: RTL and testbench

Parametrised full-duplex UART transceiver. It is the next-generation replacement for the fixed 8N1 transmit/receive pair in the serial subsystem. It adds configurable data width, oversampling, parity and stop bits, ready/valid transmit handshake, and receive error reporting (parity, framing, overrun). It sits between the host-side byte interface and the serial pins.

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/uart_xcvr_param_if.sv | 27 ++
 rtl/uart_rx_engine.sv | 136 +++++++++++++
 rtl/uart_xcvr_param.sv | 135 +++++++++++++
 tb/tb_uart_xcvr_param.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transceiver.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package uart_pkg;

    // Parity mode encodings for the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Widest payload supported; parity_bit takes data zero-extended to this
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } txState_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rxState_t;

    // Parity bit for a payload. Zero-extension does not change the XOR,
    // so callers may pass any width up to MAX_DATA_BITS.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int mode);
        logic result;
        case (mode)
            PAR_EVEN: result = ^data;
            PAR_ODD:  result = ~(^data);
            default:  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_xcvr_param_if.sv
// Host-side byte interface of the UART transceiver (transmit handshake + receive status).
// Latency: none (signal bundle only).
// Backpressure: tx_valid/tx_ready handshake on transmit; receive side has no backpressure, rx_ack only retires the pending frame.
// Ports: master = host (drives tx_valid, tx_data, rx_ack); slave = transceiver.
interface uart_xcvr_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_data;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 rx_ack;

    modport master (
        output tx_valid, tx_data, rx_ack,
        input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
    );

    modport slave (
        input  tx_valid, tx_data, rx_ack,
        output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
    );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receiver: 2-flop synchroniser, oversampled frame FSM, parity/framing/overrun reporting.
// Latency: rx_valid one cycle after the centre sample of the first stop bit (plus 2 synchroniser cycles).
// Backpressure: none; an unacknowledged frame overwritten by a new one raises sticky rx_overrun.
// Ports: sys_clk/sys_rst_l, uart_rxd (async serial in), rx_ack (host retire), rx_data/rx_valid/error flags out.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_l,
    input  logic                 uart_rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int             CW        = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  CELL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0]  CELL_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]     BIT_LAST  = 4'(DATA_BITS - 1);

    logic                 rxMeta;
    logic                 rxSync;
    rxState_t             rxState;
    logic [CW-1:0]        rxCell;
    logic [3:0]           rxBitCnt;
    logic [DATA_BITS-1:0] rxShift;
    logic                 parBad;
    logic                 pending;
    logic                 rxWrap;

    assign rxWrap = (rxCell == CELL_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            rxMeta        <= 1'b1;
            rxSync        <= 1'b1;
            rxState       <= RX_IDLE;
            rxCell        <= '0;
            rxBitCnt      <= '0;
            rxShift       <= '0;
            parBad        <= 1'b0;
            pending       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rxMeta   <= uart_rxd;
            rxSync   <= rxMeta;
            rx_valid <= 1'b0;

            // Overrun bookkeeping keys off the registered rx_valid so the host
            // sees ack and valid in the same cycle as one coherent event.
            if (rx_valid) begin
                pending <= 1'b1;
                if (rx_ack) begin
                    rx_overrun <= 1'b0;
                end else if (pending) begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                pending    <= 1'b0;
                rx_overrun <= 1'b0;
            end

            case (rxState)
                RX_IDLE: begin
                    rxCell <= '0;
                    if (!rxSync) begin
                        rxState <= RX_START;
                    end
                end
                RX_START: begin
                    // Re-check at mid start bit; a short low pulse is dropped silently
                    if (rxCell == CELL_HALF) begin
                        rxCell <= '0;
                        if (!rxSync) begin
                            rxState  <= RX_DATA;
                            rxBitCnt <= '0;
                            parBad   <= 1'b0;
                        end else begin
                            rxState <= RX_IDLE;
                        end
                    end else begin
                        rxCell <= rxCell + CW'(1);
                    end
                end
                RX_DATA: begin
                    rxCell <= rxWrap ? '0 : rxCell + CW'(1);
                    if (rxWrap) begin
                        rxShift <= {rxSync, rxShift[DATA_BITS-1:1]};
                        if (rxBitCnt == BIT_LAST) begin
                            rxState <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            rxBitCnt <= rxBitCnt + 4'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    rxCell <= rxWrap ? '0 : rxCell + CW'(1);
                    if (rxWrap) begin
                        parBad  <= (rxSync != parity_bit(MAX_DATA_BITS'(rxShift), PARITY));
                        rxState <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    rxCell <= rxWrap ? '0 : rxCell + CW'(1);
                    if (rxWrap) begin
                        rx_valid      <= 1'b1;
                        rx_data       <= rxShift;
                        rx_parity_err <= parBad;
                        rx_frame_err  <= !rxSync;
                        // A low stop bit is a break/framing fault: hold off until the line idles
                        rxState       <= rxSync ? RX_IDLE : RX_BREAK;
                    end
                end
                RX_BREAK: begin
                    rxCell <= '0;
                    if (rxSync) begin
                        rxState <= RX_IDLE;
                    end
                end
                default: rxState <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_xcvr_param.sv
// Full-duplex parametrised UART: inline transmit FSM plus uart_rx_engine receiver.
// Latency: uart_txd falls the cycle after tx_valid&&tx_ready; tx_ready returns one cycle after the last stop cell.
// Backpressure: tx_ready low for the whole frame; tx_data changes while busy are ignored. Receive has no backpressure.
// Ports: sys_clk/sys_rst_l, host (slave modport of uart_xcvr_param_if), uart_txd (serial out, idle high), uart_rxd (serial in).
module uart_xcvr_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_l,
    uart_xcvr_param_if.slave   host,
    output logic               uart_txd,
    input  logic               uart_rxd
);

    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4 || OVERSAMPLE > 64 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS ||
        PARITY < PAR_NONE || PARITY > PAR_ODD) begin : gParamCheck
        $error("uart_xcvr_param: illegal parameter combination");
    end

    localparam int             CW        = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  CELL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]     BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    txState_t             txState;
    logic [CW-1:0]        txCell;
    logic [3:0]           txBitCnt;
    logic [DATA_BITS-1:0] txShift;
    logic                 txParBit;
    logic                 txReady;
    logic                 txWrap;

    assign txWrap        = (txCell == CELL_LAST);
    assign host.tx_ready = txReady;

    // uart_txd is registered and always loaded one cell ahead: each transition
    // writes the level of the cell that begins on that same edge.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            txState  <= TX_IDLE;
            txCell   <= '0;
            txBitCnt <= '0;
            txShift  <= '0;
            txParBit <= 1'b0;
            txReady  <= 1'b1;
            uart_txd <= 1'b1;
        end else begin
            if (txState != TX_IDLE) begin
                txCell <= txWrap ? '0 : txCell + CW'(1);
            end else begin
                txCell <= '0;
            end

            case (txState)
                TX_IDLE: begin
                    if (host.tx_valid && txReady) begin
                        txShift  <= host.tx_data;
                        txParBit <= parity_bit(MAX_DATA_BITS'(host.tx_data), PARITY);
                        txReady  <= 1'b0;
                        uart_txd <= 1'b0;
                        txState  <= TX_START;
                    end
                end
                TX_START: begin
                    if (txWrap) begin
                        txState  <= TX_DATA;
                        txBitCnt <= '0;
                        uart_txd <= txShift[0];
                        txShift  <= txShift >> 1;
                    end
                end
                TX_DATA: begin
                    if (txWrap) begin
                        if (txBitCnt == BIT_LAST) begin
                            txBitCnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                txState  <= TX_PARITY;
                                uart_txd <= txParBit;
                            end else begin
                                txState  <= TX_STOP;
                                uart_txd <= 1'b1;
                            end
                        end else begin
                            txBitCnt <= txBitCnt + 4'd1;
                            uart_txd <= txShift[0];
                            txShift  <= txShift >> 1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (txWrap) begin
                        txState  <= TX_STOP;
                        txBitCnt <= '0;
                        uart_txd <= 1'b1;
                    end
                end
                TX_STOP: begin
                    if (txWrap) begin
                        if (txBitCnt == STOP_LAST) begin
                            txState <= TX_IDLE;
                            txReady <= 1'b1;
                        end else begin
                            txBitCnt <= txBitCnt + 4'd1;
                        end
                    end
                end
                default: txState <= TX_IDLE;
            endcase
        end
    end

    uart_rx_engine #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE),
        .PARITY     (PARITY)
    ) uRxEngine (
        .sys_clk       (sys_clk),
        .sys_rst_l     (sys_rst_l),
        .uart_rxd      (uart_rxd),
        .rx_ack        (host.rx_ack),
        .rx_data       (host.rx_data),
        .rx_valid      (host.rx_valid),
        .rx_parity_err (host.rx_parity_err),
        .rx_frame_err  (host.rx_frame_err),
        .rx_overrun    (host.rx_overrun)
    );

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Bench for uart_xcvr_param: three instances (8N1, 8E1 loopback, 8O1 driven), scoreboard queues with passive monitors.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_xcvr_param;
    import uart_pkg::*;

    typedef struct packed {
        logic [7:0] dat;
        logic       pe;
        logic       fe;
    } rxExp_t;

    typedef struct packed {
        logic [15:0] bits;   // frame bits in line order, bit 0 first (start bit)
        logic [4:0]  n;
    } txExp_t;

    logic sys_clk = 1'b0;
    logic sys_rst_l = 1'b0;
    logic rxd0 = 1'b1;
    logic rxd2 = 1'b1;
    logic txd0, txd1, txd2;

    int nVec = 0;
    int nMis = 0;
    logic txMonEn = 1'b1;
    logic txBusy [2];

    rxExp_t rxQ0[$];
    rxExp_t rxQ1[$];
    rxExp_t rxQ2[$];
    txExp_t txQ0[$];
    txExp_t txQ1[$];

    always #5 sys_clk = ~sys_clk;

    uart_xcvr_param_if #(.DATA_BITS(8)) hIf0 ();
    uart_xcvr_param_if #(.DATA_BITS(8)) hIf1 ();
    uart_xcvr_param_if #(.DATA_BITS(8)) hIf2 ();

    uart_xcvr_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut0 (
        .sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .host(hIf0), .uart_txd(txd0), .uart_rxd(rxd0));
    uart_xcvr_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .host(hIf1), .uart_txd(txd1), .uart_rxd(txd1));
    uart_xcvr_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) dut2 (
        .sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .host(hIf2), .uart_txd(txd2), .uart_rxd(rxd2));

    logic       txdW  [2];
    logic       rdyW  [2];
    logic       rxVldW[3];
    logic [7:0] rxDatW[3];
    logic       rxPeW [3];
    logic       rxFeW [3];

    assign txdW[0] = txd0;            assign txdW[1] = txd1;
    assign rdyW[0] = hIf0.tx_ready;   assign rdyW[1] = hIf1.tx_ready;
    assign rxVldW[0] = hIf0.rx_valid; assign rxVldW[1] = hIf1.rx_valid; assign rxVldW[2] = hIf2.rx_valid;
    assign rxDatW[0] = hIf0.rx_data;  assign rxDatW[1] = hIf1.rx_data;  assign rxDatW[2] = hIf2.rx_data;
    assign rxPeW[0] = hIf0.rx_parity_err; assign rxPeW[1] = hIf1.rx_parity_err; assign rxPeW[2] = hIf2.rx_parity_err;
    assign rxFeW[0] = hIf0.rx_frame_err;  assign rxFeW[1] = hIf1.rx_frame_err;  assign rxFeW[2] = hIf2.rx_frame_err;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    // Passive transmit monitor: a falling tx_ready marks frame start; each bit cell
    // must hold its level for 16 cycles and tx_ready must stay low n*16 cycles.
    task automatic txMonitor(input int d);
        logic prev;
        logic bad;
        logic badVal;
        logic rdyAfter;
        logic have;
        int lowCnt;
        txExp_t e;
        prev = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (prev && !rdyW[d] && txMonEn && sys_rst_l) begin
                have = 1'b0;
                if (d == 0 && txQ0.size() > 0) begin e = txQ0.pop_front(); have = 1'b1; end
                if (d == 1 && txQ1.size() > 0) begin e = txQ1.pop_front(); have = 1'b1; end
                if (!have) begin
                    nVec++; nMis++;
                    $display("FAIL tx%0d unexpected frame: tx_ready fell with no frame expected", d);
                    prev = rdyW[d];
                end else begin
                    txBusy[d] = 1'b1;
                    lowCnt = 0;
                    for (int b = 0; b < int'(e.n); b++) begin
                        bad = 1'b0;
                        badVal = 1'b0;
                        for (int c = 0; c < 16; c++) begin
                            if (b != 0 || c != 0) @(negedge sys_clk);
                            if (!rdyW[d]) lowCnt++;
                            if (txdW[d] !== e.bits[b]) begin bad = 1'b1; badVal = txdW[d]; end
                        end
                        nVec++;
                        if (bad) begin
                            nMis++;
                            $display("FAIL tx%0d bit %0d: line %b required %b for 16 cycles", d, b, badVal, e.bits[b]);
                        end
                    end
                    @(negedge sys_clk);
                    rdyAfter = rdyW[d];
                    nVec++;
                    if (lowCnt != int'(e.n) * 16 || rdyAfter !== 1'b1) begin
                        nMis++;
                        $display("FAIL tx%0d ready window: low %0d cycles then ready=%b, required %0d then 1",
                                 d, lowCnt, rdyAfter, int'(e.n) * 16);
                    end
                    prev = rdyAfter;
                    txBusy[d] = 1'b0;
                end
            end else begin
                prev = rdyW[d];
            end
        end
    endtask

    task automatic rxMonitor();
        rxExp_t e;
        rxExp_t g;
        logic have;
        forever begin
            @(negedge sys_clk);
            for (int d = 0; d < 3; d++) begin
                if (sys_rst_l && rxVldW[d]) begin
                    g = '{dat: rxDatW[d], pe: rxPeW[d], fe: rxFeW[d]};
                    have = 1'b0;
                    if (d == 0 && rxQ0.size() > 0) begin e = rxQ0.pop_front(); have = 1'b1; end
                    if (d == 1 && rxQ1.size() > 0) begin e = rxQ1.pop_front(); have = 1'b1; end
                    if (d == 2 && rxQ2.size() > 0) begin e = rxQ2.pop_front(); have = 1'b1; end
                    nVec++;
                    if (!have) begin
                        nMis++;
                        $display("FAIL rx%0d unexpected rx_valid: data=%h pe=%b fe=%b, none required", d, g.dat, g.pe, g.fe);
                    end else if (g !== e) begin
                        nMis++;
                        $display("FAIL rx%0d frame: data=%h pe=%b fe=%b required data=%h pe=%b fe=%b",
                                 d, g.dat, g.pe, g.fe, e.dat, e.pe, e.fe);
                    end
                end
            end
        end
    endtask

    task automatic waitDrain(input string nm);
        int t;
        t = 0;
        while ((txQ0.size() + txQ1.size() + rxQ0.size() + rxQ1.size() + rxQ2.size()) != 0 ||
               txBusy[0] || txBusy[1]) begin
            if (t >= 3000) break;
            @(negedge sys_clk);
            t++;
        end
        if (t >= 3000) begin
            nVec++; nMis++;
            $display("FAIL %s drain timeout: %0d tx and %0d rx expectations left, required 0", nm,
                     txQ0.size() + txQ1.size(), rxQ0.size() + rxQ1.size() + rxQ2.size());
            txQ0.delete(); txQ1.delete(); rxQ0.delete(); rxQ1.delete(); rxQ2.delete();
        end
    endtask

    task automatic sendTx(input int d, input logic [7:0] data);
        int t;
        t = 0;
        while (!rdyW[d] && t < 1000) begin @(negedge sys_clk); t++; end
        if (!rdyW[d]) begin
            nVec++; nMis++;
            $display("FAIL tx%0d ready timeout: ready=0 required 1", d);
        end else begin
            if (d == 0) begin hIf0.tx_valid = 1'b1; hIf0.tx_data = data; end
            else        begin hIf1.tx_valid = 1'b1; hIf1.tx_data = data; end
            @(negedge sys_clk);
            // Scramble tx_data while busy; the frame on the line must not change
            if (d == 0) begin hIf0.tx_valid = 1'b0; hIf0.tx_data = ~data; end
            else        begin hIf1.tx_valid = 1'b0; hIf1.tx_data = ~data; end
        end
    endtask

    task automatic driveRx(input int d, input logic [15:0] bits, input int n);
        for (int b = 0; b < n; b++) begin
            if (d == 0) rxd0 = bits[b]; else rxd2 = bits[b];
            repeat (16) @(negedge sys_clk);
        end
    endtask

    task automatic ackPulse();
        hIf0.rx_ack = 1'b1;
        @(negedge sys_clk);
        hIf0.rx_ack = 1'b0;
        @(negedge sys_clk);
    endtask

    initial begin
        txBusy[0] = 1'b0; txBusy[1] = 1'b0;
        hIf0.tx_valid = 1'b0; hIf0.tx_data = '0; hIf0.rx_ack = 1'b0;
        hIf1.tx_valid = 1'b0; hIf1.tx_data = '0; hIf1.rx_ack = 1'b0;
        hIf2.tx_valid = 1'b0; hIf2.tx_data = '0; hIf2.rx_ack = 1'b0;
        fork
            txMonitor(0);
            txMonitor(1);
            rxMonitor();
        join_none

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("reset txd",       32'(txd0), 32'h1);
        chk("reset tx_ready",  32'(hIf0.tx_ready), 32'h1);
        chk("reset rx_data",   32'(hIf0.rx_data), 32'h0);
        chk("reset rx_valid",  32'(hIf0.rx_valid), 32'h0);
        chk("reset err flags", 32'({hIf0.rx_parity_err, hIf0.rx_frame_err, hIf0.rx_overrun}), 32'h0);
        chk("reset rx state",  32'(dut0.uRxEngine.rxState), 32'(RX_IDLE));
        sys_rst_l = 1'b1;
        repeat (4) @(negedge sys_clk);

        // 8N1 transmit of 0xA5: line 0,1,0,1,0,0,1,0,1,1
        txQ0.push_back('{bits: 16'(10'b1_10100101_0), n: 5'd10});
        sendTx(0, 8'hA5);
        waitDrain("tx 0xA5");

        // Even parity loopback: 0x55 -> parity 0, 0x07 -> parity 1
        txQ1.push_back('{bits: 16'(11'b1_0_01010101_0), n: 5'd11});
        rxQ1.push_back('{dat: 8'h55, pe: 1'b0, fe: 1'b0});
        txQ1.push_back('{bits: 16'(11'b1_1_00000111_0), n: 5'd11});
        rxQ1.push_back('{dat: 8'h07, pe: 1'b0, fe: 1'b0});
        sendTx(1, 8'h55);
        sendTx(1, 8'h07);
        waitDrain("even loopback");

        // Odd parity receive: 0x07 with parity 1 is wrong, 0x3C with parity 1 is right
        rxQ2.push_back('{dat: 8'h07, pe: 1'b1, fe: 1'b0});
        driveRx(2, 16'(11'b1_1_00000111_0), 11);
        rxQ2.push_back('{dat: 8'h3C, pe: 1'b0, fe: 1'b0});
        driveRx(2, 16'(11'b1_1_00111100_0), 11);
        waitDrain("odd parity rx");

        // Start-bit glitch of 5 cycles is dropped, then a clean 0x3C frame
        rxd0 = 1'b0;
        repeat (5) @(negedge sys_clk);
        rxd0 = 1'b1;
        repeat (30) @(negedge sys_clk);
        chk("glitch back to idle", 32'(dut0.uRxEngine.rxState), 32'(RX_IDLE));
        rxQ0.push_back('{dat: 8'h3C, pe: 1'b0, fe: 1'b0});
        driveRx(0, 16'(10'b1_00111100_0), 10);
        waitDrain("rx after glitch");
        ackPulse();

        // 0x81 with stop bit held low for 40 cycles
        rxQ0.push_back('{dat: 8'h81, pe: 1'b0, fe: 1'b1});
        driveRx(0, 16'(9'b10000001_0), 9);
        rxd0 = 1'b0;
        repeat (40) @(negedge sys_clk);
        chk("break holds while low", 32'(dut0.uRxEngine.rxState), 32'(RX_BREAK));
        rxd0 = 1'b1;
        waitDrain("framing error");
        chk("frame_err holds", 32'(hIf0.rx_frame_err), 32'h1);
        ackPulse();
        rxQ0.push_back('{dat: 8'h5A, pe: 1'b0, fe: 1'b0});
        driveRx(0, 16'(10'b1_01011010_0), 10);
        waitDrain("rx after break");
        chk("frame_err cleared", 32'(hIf0.rx_frame_err), 32'h0);
        ackPulse();

        // Overrun: two frames with no ack in between
        rxQ0.push_back('{dat: 8'h11, pe: 1'b0, fe: 1'b0});
        driveRx(0, 16'(10'b1_00010001_0), 10);
        waitDrain("overrun first");
        repeat (2) @(negedge sys_clk);
        chk("no overrun after one", 32'(hIf0.rx_overrun), 32'h0);
        rxQ0.push_back('{dat: 8'h22, pe: 1'b0, fe: 1'b0});
        driveRx(0, 16'(10'b1_00100010_0), 10);
        waitDrain("overrun second");
        repeat (2) @(negedge sys_clk);
        chk("overrun set", 32'(hIf0.rx_overrun), 32'h1);
        ackPulse();
        chk("overrun cleared by ack", 32'(hIf0.rx_overrun), 32'h0);

        // Asynchronous reset in the middle of a transmit (data bit 2 of 0xF0 is low)
        txMonEn = 1'b0;
        sendTx(0, 8'hF0);
        repeat (50) @(negedge sys_clk);
        chk("mid-frame txd", 32'(txd0), 32'h0);
        chk("mid-frame tx_ready", 32'(hIf0.tx_ready), 32'h0);
        #2 sys_rst_l = 1'b0;
        #1;
        chk("async reset txd", 32'(txd0), 32'h1);
        chk("async reset tx_ready", 32'(hIf0.tx_ready), 32'h1);
        @(negedge sys_clk);
        sys_rst_l = 1'b1;
        repeat (40) @(negedge sys_clk);
        chk("no partial frame txd", 32'(txd0), 32'h1);
        chk("no partial frame ready", 32'(hIf0.tx_ready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

    // Global watchdog so the run always ends on its own
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
